// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word requests to a word-addressed memory; loads return after 1 cycle,
// sub-word stores take 2 cycles (read, then merged write) with req_ready low in the second.
module mem_access_unit #(
  parameter int MEM_DEPTH = 32,
  parameter int IDX_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        misalign_err,
  output logic        range_err,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, MERGE_WR} state_t;

  localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);

  state_t             state_q, state_d;
  logic [31:0]        merge_q, merge_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [4:0]         resp_rd_q, resp_rd_d;
  logic               misalign_q, misalign_d;
  logic               range_q, range_d;

  logic [IDX_W-1:0]   req_idx;
  logic               accept, misaligned, out_of_range;
  logic [31:0]        shifted, load_ext, merged;

  assign req_idx      = req_addr[IDX_W+1:2];
  assign accept       = req_valid & req_ready;
  assign misaligned   = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign out_of_range = req_addr[31:2] >= DEPTH_W;

  // Shifting the addressed lane down to bit 0 serves byte, half and word alike.
  assign shifted = mem_rdata >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (req_size)
      2'b00:   load_ext = req_unsigned ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = req_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (req_size == 2'b00) begin
      case (req_addr[1:0])
        2'b00:   merged[7:0]   = req_wdata[7:0];
        2'b01:   merged[15:8]  = req_wdata[7:0];
        2'b10:   merged[23:16] = req_wdata[7:0];
        default: merged[31:24] = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      merged[31:16] = req_wdata[15:0];
    end else begin
      merged[15:0] = req_wdata[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    idx_d        = idx_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = 5'd0;
    misalign_d   = 1'b0;
    range_d      = 1'b0;
    req_ready    = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (accept) begin
          if (misaligned || out_of_range) begin
            // Misalignment wins when both apply; failed loads still answer with zero data.
            misalign_d = misaligned;
            range_d    = ~misaligned;
            if (!req_we) begin
              resp_valid_d = 1'b1;
              resp_rdata_d = 32'd0;
              resp_rd_d    = req_rd;
            end
          end else if (!req_we) begin
            mem_re       = 1'b1;
            mem_addr     = 32'(req_idx);
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
            resp_rd_d    = req_rd;
          end else if (req_size == 2'b10) begin
            mem_we    = 1'b1;
            mem_addr  = 32'(req_idx);
            mem_wdata = req_wdata;
          end else begin
            mem_re   = 1'b1;
            mem_addr = 32'(req_idx);
            merge_d  = merged;
            idx_d    = req_idx;
            state_d  = MERGE_WR;
          end
        end
      end
      MERGE_WR: begin
        mem_we    = rst_n;
        mem_addr  = 32'(idx_q);
        mem_wdata = merge_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      merge_q      <= 32'd0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_rd_q    <= 5'd0;
      misalign_q   <= 1'b0;
      range_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      misalign_q   <= misalign_d;
      range_q      <= range_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_rd      = resp_rd_q;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 32x32 data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        misalign_err, range_err;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_DEPTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .misalign_err(misalign_err), .range_err(range_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_re ? mem[mem_addr[4:0]] : 32'd0;
  always @(posedge clk) if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[1] = 32'h0000_0001;
    mem[2] = 32'h0000_000B;
    idle_req();
    rst_n = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_we",    32'(mem_we),    32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready),    32'd1);
    check("post_rst_vld",   32'(resp_valid),   32'd0);
    check("post_rst_rdata", resp_rdata,        32'd0);
    check("post_rst_mis",   32'(misalign_err), 32'd0);
    check("post_rst_rng",   32'(range_err),    32'd0);

    // Back-to-back word loads
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd1);
    #1;
    check("ld0_re",   32'(mem_re), 32'd1);
    check("ld0_addr", mem_addr,    32'd0);
    tick();
    check("ld0_vld",  32'(resp_valid), 32'd1);
    check("ld0_data", resp_rdata,      32'h0);
    check("ld0_rd",   32'(resp_rd),    32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd2);
    #1;
    check("ld1_addr", mem_addr, 32'd1);
    tick();
    check("ld1_vld",  32'(resp_valid), 32'd1);
    check("ld1_data", resp_rdata,      32'h1);
    check("ld1_rd",   32'(resp_rd),    32'd2);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 5'd7);
    #1;
    check("ld2_re",   32'(mem_re), 32'd1);
    check("ld2_addr", mem_addr,    32'd2);
    tick();
    check("ld2_vld",  32'(resp_valid), 32'd1);
    check("ld2_data", resp_rdata,      32'h0000_000B);
    check("ld2_rd",   32'(resp_rd),    32'd7);
    idle_req();
    tick();
    check("idle_vld", 32'(resp_valid), 32'd0);

    // Byte store with a load held upstream during the merge-write cycle
    issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 5'd0);
    #1;
    check("sb_re", 32'(mem_re), 32'd1);
    check("sb_we", 32'(mem_we), 32'd0);
    tick();
    issue(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 5'd4);
    #1;
    check("sb_mw_ready", 32'(req_ready), 32'd0);
    check("sb_mw_we",    32'(mem_we),    32'd1);
    check("sb_mw_re",    32'(mem_re),    32'd0);
    check("sb_mw_addr",  mem_addr,       32'd1);
    check("sb_mw_wdata", mem_wdata,      32'h0000_AB01);
    tick();
    check("held_not_taken", 32'(resp_valid), 32'd0);
    check("lb_re", 32'(mem_re), 32'd1);
    tick();
    check("lb_vld",  32'(resp_valid), 32'd1);
    check("lb_data", resp_rdata,      32'hFFFF_FFAB);
    check("lb_rd",   32'(resp_rd),    32'd4);
    issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 5'd5);
    tick();
    check("lbu_data", resp_rdata, 32'h0000_00AB);

    // Half store into the upper lane of word 2
    issue(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_1234, 5'd0);
    tick();
    idle_req();
    #1;
    check("sh_we",    32'(mem_we), 32'd1);
    check("sh_addr",  mem_addr,    32'd2);
    check("sh_wdata", mem_wdata,   32'h1234_000B);
    tick();
    issue(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 5'd6);
    tick();
    check("lh_data", resp_rdata, 32'h0000_1234);
    issue(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 5'd6);
    tick();
    check("lhu_lo_data", resp_rdata, 32'h0000_000B);

    // Error paths
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 5'd9);
    #1;
    check("mis_re", 32'(mem_re), 32'd0);
    check("mis_we", 32'(mem_we), 32'd0);
    tick();
    check("mis_err",  32'(misalign_err), 32'd1);
    check("mis_rng",  32'(range_err),    32'd0);
    check("mis_vld",  32'(resp_valid),   32'd1);
    check("mis_data", resp_rdata,        32'd0);
    check("mis_rd",   32'(resp_rd),      32'd9);
    issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h1111_1111, 5'd0);
    #1;
    check("rng_we", 32'(mem_we), 32'd0);
    tick();
    check("rng_err", 32'(range_err),    32'd1);
    check("rng_mis", 32'(misalign_err), 32'd0);
    check("rng_vld", 32'(resp_valid),   32'd0);
    issue(1'b0, 2'b01, 1'b0, 32'h81, 32'h0, 5'd3);
    tick();
    check("prio_mis", 32'(misalign_err), 32'd1);
    check("prio_rng", 32'(range_err),    32'd0);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 5'd3);
    #1;
    check("sz11_re", 32'(mem_re), 32'd0);
    tick();
    check("sz11_mis", 32'(misalign_err), 32'd1);
    idle_req();
    tick();
    check("err_clear", 32'(misalign_err | range_err), 32'd0);

    // Word store, then reset during the merge-write of a byte store to the same word
    issue(1'b1, 2'b10, 1'b0, 32'hC, 32'hDEAD_BEEF, 5'd0);
    #1;
    check("sw_we",    32'(mem_we), 32'd1);
    check("sw_addr",  mem_addr,    32'd3);
    check("sw_wdata", mem_wdata,   32'hDEAD_BEEF);
    tick();
    issue(1'b1, 2'b00, 1'b0, 32'hC, 32'h0000_0055, 5'd0);
    tick();
    idle_req();
    rst_n = 1'b0;
    #1;
    check("rst_mw_we", 32'(mem_we), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(req_ready),    32'd1);
    check("rel_vld",   32'(resp_valid),   32'd0);
    check("rel_rdata", resp_rdata,        32'd0);
    check("rel_mis",   32'(misalign_err), 32'd0);
    check("rel_rng",   32'(range_err),    32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 5'd8);
    tick();
    idle_req();
    check("rst_word_kept", resp_rdata, 32'hDEAD_BEEF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the EX/MEM pipeline register and the word-addressed data memory (32 x 32-bit, synchronous write, combinational read gated by read enable).
- Converts byte-addressed byte/half/word requests into word accesses.
- Sub-word stores use read-modify-write.
- Load results are sign- or zero-extended and returned registered to the MEM/WB stage.

Parameters:
- MEM_DEPTH, 32, number of 32-bit words in the data memory; word index range 0..MEM_DEPTH-1.
- IDX_W, 5, width of the word index, equal to clog2(MEM_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as a misaligned access.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  destination register tag for loads.
- resp_valid  out  1  load result valid, one-cycle pulse.
- resp_rdata  out  32  extended load data.
- resp_rd  out  5  tag echoed with resp_valid.
- misalign_err  out  1  one-cycle pulse on a misaligned request.
- range_err  out  1  one-cycle pulse on an out-of-range request.
- mem_we  out  1  data memory write enable.
- mem_re  out  1  data memory read enable.
- mem_addr  out  32  word index, zero-extended.
- mem_wdata  out  32  data memory write data.
- mem_rdata  in  32  data memory read data, combinational.

Behaviour:
- Accept condition: req_valid & req_ready. Word index = req_addr[IDX_W+1:2]. Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1] (low half when 0).
- Reset (rst_n=0 at posedge): state to IDLE. resp_valid, resp_rdata, resp_rd, misalign_err, range_err, merge buffer all cleared to 0. While rst_n=0: req_ready=0, mem_we=0, mem_re=0.
- States: IDLE, MERGE_WR.
- IDLE: req_ready=1. mem_* are driven combinationally from the request in the accept cycle:
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0; size=11):
    - no memory access (mem_re=mem_we=0).
    - next cycle: misalign_err=1.
    - load: also resp_valid=1, resp_rdata=0.
  - Out of range (addr[31:2] >= MEM_DEPTH), when aligned:
    - same handling as misaligned, but raises range_err instead.
    - misalignment has priority if both apply.
  - Load:
    - mem_re=1, mem_addr=index.
    - At posedge, select lane from mem_rdata, extend, register.
    - Next cycle: resp_valid=1, resp_rdata, resp_rd. Latency 1.
    - Back-to-back loads accepted every cycle.
  - Word store:
    - mem_we=1, mem_wdata=req_wdata; memory writes at this posedge.
    - No response. Stay IDLE.
  - Byte/half store:
    - mem_re=1.
    - At posedge, merge buffer <= mem_rdata with the selected lane replaced by req_wdata[7:0] or [15:0]; latch index.
    - Next state MERGE_WR.
- MERGE_WR:
  - req_ready=0; mem_we=1, mem_addr=latched index, mem_wdata=merge buffer.
  - Return to IDLE next cycle. Sub-word store occupies 2 cycles.
- Outputs without an event are 0 in every cycle. resp_rdata holds its last value but is only meaningful with resp_valid.
- mem_we and mem_re are never both 1 in the same cycle.
- Reset asserted in MERGE_WR: the write is suppressed (mem_we=0 that cycle) and the state returns to IDLE.
- Request presented while req_ready=0: ignored. The upstream stage holds it.

Test Plan:
- Memory word 2 = 0x0000000B; word load, addr 0x08, rd=7 -> mem_re=1 with mem_addr=2 in the accept cycle. Next cycle: resp_valid=1, resp_rdata=0x0000000B, resp_rd=7.
- Word 1 = 0x00000001; byte store 0xAB to addr 0x05:
  - cycle0: mem_re=1.
  - cycle1: req_ready=0, mem_we=1, mem_addr=1, mem_wdata=0x0000AB01.
  - Then signed byte load 0x05 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half store 0x1234 to addr 0x0A with word 2 = 0x0000000B -> mem_wdata=0x1234000B. Signed half load 0x0A -> 0x00001234.
- Word load 0x06 -> mem_re=0, mem_we=0; next cycle misalign_err=1, resp_valid=1, resp_rdata=0. Word store 0x80 -> no mem_we; next cycle range_err=1, resp_valid=0.
- Three word loads on consecutive cycles (addr 0x0, 0x4, 0x8) -> resp_valid high three consecutive cycles with 0x0, 0x1, 0xB in order.
- rst_n=0 in the MERGE_WR cycle of a byte store -> mem_we=0, memory word unchanged. After release: IDLE, req_ready=1, all response/error outputs 0.
